// File: rtl/pe_conv_sched.sv
// rtl/pe_conv_sched.sv - single-PE scheduler for a 4x4 by 3x3 valid convolution (2x2 results)
// Optional PE_SCHED_CYCLE_CNT_EN adds a run_cycles output reporting busy cycles of the last run.
module pe_conv_sched #(
    parameter int DW    = 8,
    parameter int ACC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [16*DW-1:0]   a_flat,
    input  logic [9*DW-1:0]    b_flat,
    input  logic [ACC_W-1:0]   pe_out,
    output logic               pe_clear,
    output logic [DW-1:0]      pe_din,
    output logic [DW-1:0]      pe_win,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   c00,
    output logic [ACC_W-1:0]   c01,
    output logic [ACC_W-1:0]   c10,
    output logic [ACC_W-1:0]   c11
`ifdef PE_SCHED_CYCLE_CNT_EN
    ,
    output logic [7:0]         run_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          w_q;
    logic [3:0]          k_q;
    logic [16*DW-1:0]    a_q;
    logic [9*DW-1:0]     b_q;

    logic [1:0]          tap_i;
    logic [3:0]          tap_j;
    logic [3:0]          a_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_MAC;
            S_MAC:     if (k_q == 4'd8) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (w_q == 2'd3) ? S_DONE : S_MAC;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Tap k maps to kernel row/col; window w picks the top-left corner in a.
    always_comb begin
        tap_i = (k_q >= 4'd6) ? 2'd2 : ((k_q >= 4'd3) ? 2'd1 : 2'd0);
        tap_j = k_q - {1'b0, tap_i, 1'b0} - {2'b00, tap_i};
        a_idx = {1'b0, w_q[1], 2'b00} + {3'b000, w_q[0]} + {tap_i, 2'b00} + tap_j;
    end

    always_comb begin
        pe_clear = 1'b1;
        pe_din   = '0;
        pe_win   = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_CLEAR, S_CAPTURE: busy = 1'b1;
            S_MAC: begin
                busy     = 1'b1;
                pe_clear = 1'b0;
                pe_din   = a_q[a_idx*DW +: DW];
                pe_win   = b_q[k_q*DW +: DW];
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
            k_q <= '0;
            a_q <= '0;
            b_q <= '0;
            c00 <= '0;
            c01 <= '0;
            c10 <= '0;
            c11 <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q <= a_flat;
                        b_q <= b_flat;
                    end
                end
                S_CLEAR: begin
                    w_q <= '0;
                    k_q <= '0;
                end
                S_MAC: begin
                    k_q <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
                end
                S_CAPTURE: begin
                    case (w_q)
                        2'd0: c00 <= pe_out;
                        2'd1: c01 <= pe_out;
                        2'd2: c10 <= pe_out;
                        default: c11 <= pe_out;
                    endcase
                    w_q <= w_q + 2'd1;
                    k_q <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef PE_SCHED_CYCLE_CNT_EN
    logic [7:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= '0;
            run_cycles <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                cyc_q <= '0;
            end else if (busy) begin
                cyc_q <= cyc_q + 8'd1;
            end
            if (state_q == S_DONE) begin
                run_cycles <= cyc_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_conv_sched.sv
// tb/tb_pe_conv_sched.sv - scoreboard bench for pe_conv_sched with a behavioural PE
module tb_pe_conv_sched;
    localparam int DW    = 8;
    localparam int ACC_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [16*DW-1:0]   a_flat;
    logic [9*DW-1:0]    b_flat;
    logic [ACC_W-1:0]   pe_out;
    logic               pe_clear;
    logic [DW-1:0]      pe_din;
    logic [DW-1:0]      pe_win;
    logic               busy;
    logic               done;
    logic [ACC_W-1:0]   c00, c01, c10, c11;
`ifdef PE_SCHED_CYCLE_CNT_EN
    logic [7:0]         run_cycles;
`endif

    pe_conv_sched #(.DW(DW), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .pe_out     (pe_out),
        .pe_clear   (pe_clear),
        .pe_din     (pe_din),
        .pe_win     (pe_win),
        .busy       (busy),
        .done       (done),
        .c00        (c00),
        .c01        (c01),
        .c10        (c10),
        .c11        (c11)
`ifdef PE_SCHED_CYCLE_CNT_EN
        ,
        .run_cycles (run_cycles)
`endif
    );

    always #5 clk = ~clk;

    logic [ACC_W-1:0] acc;
    always @(posedge clk) begin
        if (pe_clear) acc <= '0;
        else          acc <= acc + ACC_W'(pe_din * pe_win);
    end
    assign pe_out = acc;

    int n_checks = 0;
    int n_errors = 0;
    logic [4*ACC_W-1:0] sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*ACC_W-1:0] ref_conv(input logic [16*DW-1:0] a, input logic [9*DW-1:0] b);
        logic [4*ACC_W-1:0] res;
        res = '0;
        for (int w = 0; w < 4; w++) begin
            int s;
            s = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    s += int'(a[((w/2 + i)*4 + (w%2) + j)*DW +: DW]) * int'(b[(i*3 + j)*DW +: DW]);
            res[(3-w)*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return res;
    endfunction

    logic done_d = 1'b0;
    always @(posedge clk) begin
        logic [4*ACC_W-1:0] exp;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp = sb.pop_front();
                check("c00", c00, exp[3*ACC_W +: ACC_W]);
                check("c01", c01, exp[2*ACC_W +: ACC_W]);
                check("c10", c10, exp[1*ACC_W +: ACC_W]);
                check("c11", c11, exp[0 +: ACC_W]);
            end
        end
`ifdef PE_SCHED_CYCLE_CNT_EN
        if (done_d) check("run_cycles", run_cycles, 64'd41);
`endif
        done_d = done;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives start in cycle 0 and checks busy/done for cycles 1..43.
    task automatic run(input logic [16*DW-1:0] a, input logic [9*DW-1:0] b, input bit chk_k4);
        a_flat = a;
        b_flat = b;
        sb.push_back(ref_conv(a, b));
        start = 1'b1;
        for (int cycle = 1; cycle <= 43; cycle++) begin
            tick;
            if (cycle == 1) start = 1'b0;
            check("busy", {63'd0, busy}, {63'd0, (cycle <= 41)});
            check("done", {63'd0, done}, {63'd0, (cycle == 42)});
            if (chk_k4 && cycle == 6) begin
                check("k4_din", pe_din, 64'd5);
                check("k4_win", pe_win, 64'd1);
            end
        end
    endtask

    logic [16*DW-1:0] a_ones, a_ramp, a_16, a_ff;
    logic [9*DW-1:0]  b_ones, b_mid, b_2;

    initial begin
        int t, last, ndone;
        for (int n = 0; n < 16; n++) begin
            a_ones[n*DW +: DW] = 8'd1;
            a_ramp[n*DW +: DW] = DW'(n);
            a_16[n*DW +: DW]   = 8'd16;
            a_ff[n*DW +: DW]   = 8'hFF;
        end
        for (int n = 0; n < 9; n++) begin
            b_ones[n*DW +: DW] = 8'd1;
            b_mid[n*DW +: DW]  = (n == 4) ? 8'd1 : 8'd0;
            b_2[n*DW +: DW]    = 8'd2;
        end

        rst = 1'b1; start = 1'b0; a_flat = '0; b_flat = '0;
        tick; tick;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_clear", {63'd0, pe_clear}, 64'd1);
        check("rst_din", pe_din, 64'd0);
        check("rst_win", pe_win, 64'd0);
        check("rst_c", {c00, c01, c10, c11}, 64'd0);
        rst = 1'b0;
        tick;

        run(a_ones, b_ones, 1'b0);
        run(a_ramp, b_mid, 1'b1);
        run(a_16, b_2, 1'b0);

        // Operand change and start pulse mid-run must not disturb the run.
        a_flat = a_ones; b_flat = b_ones;
        sb.push_back(ref_conv(a_ones, b_ones));
        start = 1'b1;
        for (int cycle = 1; cycle <= 47; cycle++) begin
            tick;
            start = (cycle == 20);
            if (cycle == 15) a_flat = a_ff;
            if (cycle >= 43) check("idle_after", {63'd0, busy}, 64'd0);
        end

        // Reset in cycle 25 aborts the run.
        a_flat = a_ramp; b_flat = b_mid;
        start = 1'b1;
        for (int cycle = 1; cycle <= 25; cycle++) begin
            tick;
            if (cycle == 1) start = 1'b0;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_clear", {63'd0, pe_clear}, 64'd1);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_c", {c00, c01, c10, c11}, 64'd0);
        tick;
        run(a_ramp, b_mid, 1'b0);

        // Held start: back-to-back runs every 43 cycles.
        a_flat = a_ones; b_flat = b_ones;
        for (int n = 0; n < 3; n++) sb.push_back(ref_conv(a_ones, b_ones));
        start = 1'b1;
        t = 0; last = -1; ndone = 0;
        while (t < 200 && ndone < 3) begin
            tick;
            t++;
            if (done) begin
                if (last >= 0) check("done_period", 64'(t - last), 64'd43);
                last = t;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        check("held_runs", 64'(ndone), 64'd3);
        tick; tick; tick;
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
